// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, registered syncs/blank and the RGB output stage.
// Define VGA_TEST_PATTERN_EN to replace pix_data with eight vertical colour bars.
module vga_timing_gen #(
  parameter int HDISP  = 800,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VDISP  = 480,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_rd,
  input  logic [23:0] pix_data,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start
);

  localparam int HTOT = HDISP + HFP + HPULSE + HBP;
  localparam int VTOT = VDISP + VFP + VPULSE + VBP;

  localparam logic [10:0] H_LAST = 11'(HTOT - 1);
  localparam logic [10:0] H_ACT  = 11'(HDISP);
  localparam logic [10:0] H_PS   = 11'(HDISP + HFP);
  localparam logic [10:0] H_PE   = 11'(HDISP + HFP + HPULSE);
  localparam logic [9:0]  V_LAST = 10'(VTOT - 1);
  localparam logic [9:0]  V_ACT  = 10'(VDISP);
  localparam logic [9:0]  V_PS   = 10'(VDISP + VFP);
  localparam logic [9:0]  V_PE   = 10'(VDISP + VFP + VPULSE);

  logic [10:0] r_hcnt;
  logic [9:0]  r_vcnt;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank;
  logic        w_hwrap;
  logic        w_vwrap;
  logic        w_act;
  logic        w_hs_n;
  logic        w_vs_n;
  logic [23:0] w_rgb;

  assign w_hwrap = (r_hcnt == H_LAST);
  assign w_vwrap = (r_vcnt == V_LAST);
  assign w_act   = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hs_n  = !((r_hcnt >= H_PS) && (r_hcnt < H_PE));
  assign w_vs_n  = !((r_vcnt >= V_PS) && (r_vcnt < V_PE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_hwrap) begin
      r_hcnt <= '0;
      r_vcnt <= w_vwrap ? '0 : r_vcnt + 10'd1;
    end else begin
      r_hcnt <= r_hcnt + 11'd1;
    end
  end

  // One-cycle stage so syncs/blank line up with pix_data returning
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_blank <= 1'b0;
    end else begin
      r_hs    <= w_hs_n;
      r_vs    <= w_vs_n;
      r_blank <= w_act;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [10:0] BARW = 11'(HDISP / 8);

  logic [10:0] r_hcnt_d;
  logic [10:0] w_bar;
  logic [2:0]  w_idx;
  logic        w_unused_pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hcnt_d <= '0;
    else     r_hcnt_d <= r_hcnt;
  end

  // Bars: white, yellow, cyan, green, magenta, red, blue, black
  assign w_bar        = r_hcnt_d / BARW;
  assign w_idx        = (w_bar > 11'd7) ? 3'd7 : w_bar[2:0];
  assign w_rgb        = {{8{~w_idx[1]}}, {8{~w_idx[2]}}, {8{~w_idx[0]}}};
  assign w_unused_pix = ^pix_data;
`else
  assign w_rgb = pix_data;
`endif

  assign pix_rd      = w_act;
  assign pixel_x     = r_hcnt;
  assign pixel_y     = r_vcnt;
  assign frame_start = (r_hcnt == 11'd0) && (r_vcnt == 10'd0);
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK   = r_blank;
  assign {VGA_R, VGA_G, VGA_B} = r_blank ? w_rgb : 24'd0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: raster-position model checked every cycle, with random resets.
// A default-parameter instance pins the 928-clock line timing.
module tb_vga_timing_gen;

  localparam int HD = 16, HF = 3, HP = 4, HB = 5;
  localparam int VD = 6, VF = 2, VP = 2, VB = 3;
  localparam int HT = HD + HF + HP + HB;
  localparam int VT = VD + VF + VP + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_data = '0;
  logic        pix_rd, hs, vs, blank, fs;
  logic [7:0]  r, g, b;
  logic [10:0] px;
  logic [9:0]  py;

  logic [23:0] d_pd = '0;
  logic        d_rd, d_hs, d_vs, d_bl, d_fs;
  logic [7:0]  d_r, d_g, d_b;
  logic [10:0] d_x;
  logic [9:0]  d_y;

  vga_timing_gen #(
    .HDISP(HD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VDISP(VD), .VFP(VF), .VPULSE(VP), .VBP(VB)
  ) dut (
    .clk(clk), .rst(rst), .pix_rd(pix_rd), .pix_data(pix_data),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK(blank),
    .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .pixel_x(px), .pixel_y(py), .frame_start(fs)
  );

  vga_timing_gen dut2 (
    .clk(clk), .rst(rst), .pix_rd(d_rd), .pix_data(d_pd),
    .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK(d_bl),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
    .pixel_x(d_x), .pixel_y(d_y), .frame_start(d_fs)
  );

  always #5 clk = ~clk;

  int k = 0;
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;

  int t_hs = -1, t_vs = -1, t_bl = -1, t_fs = -1, nrd = 0;
  int t_dhs = -1, t_dbl = -1;
  logic p_hs = 1, p_vs = 1, p_bl = 0, p_dhs = 1, p_dbl = 0;

  function automatic int hpos(int kk);
    return kk % HT;
  endfunction

  function automatic int vpos(int kk);
    return (kk / HT) % VT;
  endfunction

  function automatic logic act(int kk);
    return (hpos(kk) < HD) && (vpos(kk) < VD);
  endfunction

  function automatic logic [23:0] pat(int kk);
    return {8'(vpos(kk)), 8'(hpos(kk)), 8'hA5};
  endfunction

  function automatic logic [23:0] exp_rgb(int kk);
    if (kk == 0 || !act(kk - 1)) return 24'd0;
`ifdef VGA_TEST_PATTERN_EN
    case (hpos(kk - 1) / (HD / 8))
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
`else
    return pat(kk - 1);
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d, k %0d)",
               nm, got, want, cyc, k);
    end
  endtask

  task automatic check();
    int h, v, hp, vp;
    h = hpos(k);
    v = vpos(k);
    chk("pix_rd", 32'(pix_rd), 32'(act(k)));
    chk("pixel_x", 32'(px), h);
    chk("pixel_y", 32'(py), v);
    chk("frame_start", 32'(fs), 32'(h == 0 && v == 0));
    if (k == 0) begin
      chk("hs_rst", 32'(hs), 1);
      chk("vs_rst", 32'(vs), 1);
      chk("blank_rst", 32'(blank), 0);
      chk("rgb_rst", 32'({r, g, b}), 0);
    end else begin
      hp = hpos(k - 1);
      vp = vpos(k - 1);
      chk("hs", 32'(hs), 32'(!(hp >= HD + HF && hp < HD + HF + HP)));
      chk("vs", 32'(vs), 32'(!(vp >= VD + VF && vp < VD + VF + VP)));
      chk("blank", 32'(blank), 32'(act(k - 1)));
      chk("rgb", 32'({r, g, b}), 32'(exp_rgb(k)));
    end
  endtask

  task automatic measure();
    if (rst) begin
      t_hs = -1; t_vs = -1; t_bl = -1; t_fs = -1; nrd = 0;
      t_dhs = -1; t_dbl = -1;
    end else begin
      if (p_hs && !hs) begin
        if (t_hs >= 0) chk("hs_period", cyc - t_hs, 28);
        t_hs = cyc;
      end
      if (!p_hs && hs && t_hs >= 0) chk("hs_low", cyc - t_hs, 4);
      if (p_vs && !vs) begin
        if (t_vs >= 0) chk("vs_period", cyc - t_vs, 364);
        t_vs = cyc;
      end
      if (!p_vs && vs && t_vs >= 0) chk("vs_low", cyc - t_vs, 56);
      if (!p_bl && blank) t_bl = cyc;
      if (p_bl && !blank && t_bl >= 0) chk("blank_high", cyc - t_bl, 16);
      if (fs) begin
        if (t_fs >= 0) begin
          chk("fs_period", cyc - t_fs, 364);
          chk("rd_per_frame", nrd, 96);
        end
        t_fs = cyc;
        nrd = 0;
      end
      if (pix_rd) nrd++;
      if (p_dhs && !d_hs) begin
        if (t_dhs >= 0) chk("d_hs_period", cyc - t_dhs, 928);
        t_dhs = cyc;
      end
      if (!p_dhs && d_hs && t_dhs >= 0) chk("d_hs_low", cyc - t_dhs, 48);
      if (!p_dbl && d_bl) t_dbl = cyc;
      if (p_dbl && !d_bl && t_dbl >= 0) chk("d_blank_high", cyc - t_dbl, 800);
    end
    p_hs = hs; p_vs = vs; p_bl = blank; p_dhs = d_hs; p_dbl = d_bl;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst) k++;
    #1;
    pix_data = (k > 0 && act(k - 1)) ? pat(k - 1) : 24'($urandom);
    #1;
    check();
    measure();
  endtask

  task automatic release_rst();
    #1 rst = 1'b0;
    #1;
    chk("fs_after_release", 32'(fs), 1);
    chk("x_after_release", 32'(px), 0);
    check();
  endtask

  task automatic do_reset(int hold);
    #1 rst = 1'b1;
    k = 0;
    #1;
    check();
    repeat (hold) step();
    release_rst();
  endtask

  initial begin
    int guard;
    repeat (3) step();
    chk("d_fs_rst", 32'(d_fs), 1);
    chk("d_hs_rst", 32'(d_hs), 1);
    chk("d_blank_rst", 32'(d_bl), 0);
    release_rst();
    repeat (2200) step();

    guard = 0;
    while (!(vpos(k) == 4 && hpos(k) == 10) && guard < HT * VT + 2) begin
      step();
      guard++;
    end
    chk("reach_mid_frame", 32'(py), 4);
    do_reset(3);
    repeat (3 * HT * VT / 2) step();

    repeat (20) begin
      repeat ($urandom_range(0, 900)) step();
      do_reset($urandom_range(1, 4));
    end
    repeat (1200) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL expose parameter HDISP, default 800: active pixels per line.
REQ-002 SHALL expose parameter HFP, default 40: horizontal front porch, in pixels.
REQ-003 SHALL expose parameter HPULSE, default 48: HS pulse width, in pixels.
REQ-004 SHALL expose parameter HBP, default 40: horizontal back porch, in pixels.
REQ-005 SHALL expose parameter VDISP, default 480: active lines per frame.
REQ-006 SHALL expose parameter VFP, default 13: vertical front porch, in lines.
REQ-007 SHALL expose parameter VPULSE, default 3: VS pulse width, in lines.
REQ-008 SHALL expose parameter VBP, default 29: vertical back porch, in lines.
REQ-009 SHALL have port clk, input, 1 bit: pixel clock, the only clock.
REQ-010 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-011 SHALL have port pix_rd, output, 1 bit: pixel request to the upstream frame buffer.
REQ-012 SHALL have port pix_data, input, 24 bits: RGB888 pixel ({R,G,B}), valid one cycle after pix_rd.
REQ-013 SHALL have port VGA_HS, output, 1 bit: horizontal sync, active-low.
REQ-014 SHALL have port VGA_VS, output, 1 bit: vertical sync, active-low.
REQ-015 SHALL have port VGA_BLANK, output, 1 bit: low outside the active area.
REQ-016 SHALL have ports VGA_R, VGA_G and VGA_B, outputs, 8 bits each: colour channels.
REQ-017 SHALL have ports pixel_x (output, 11 bits) and pixel_y (output, 10 bits): coordinates of the current request.
REQ-018 SHALL have port frame_start, output, 1 bit: one-cycle pulse at pixel (0,0).

Function
REQ-019 SHALL keep hcnt in 0..HTOT-1, with HTOT = HDISP+HFP+HPULSE+HBP; hcnt wraps to 0 after HTOT-1.
REQ-020 SHALL keep vcnt in 0..VTOT-1, with VTOT = VDISP+VFP+VPULSE+VBP; vcnt increments only on hcnt wrap and wraps to 0 after VTOT-1.
REQ-021 SHALL order each line as active [0,HDISP), then front porch, then pulse, then back porch; frames follow the same order vertically.
REQ-022 SHALL assert pix_rd combinationally when hcnt<HDISP and vcnt<VDISP; pixel_x=hcnt and pixel_y=vcnt in that cycle.
REQ-023 SHALL assert frame_start combinationally when hcnt=0 and vcnt=0, for exactly one cycle per frame.
REQ-024 SHALL register VGA_HS, VGA_VS, VGA_BLANK and VGA_R/G/B with one cycle of latency from the counters, aligned with pix_data.
REQ-025 SHALL drive VGA_HS low when hcnt is in [HDISP+HFP, HDISP+HFP+HPULSE), delayed per REQ-024.
REQ-026 SHALL drive VGA_VS low for the VPULSE whole lines starting at vcnt=VDISP+VFP, delayed per REQ-024.
REQ-027 SHALL force VGA_R/G/B to 0 whenever VGA_BLANK is low.
REQ-028 SHALL produce exactly HDISP*VDISP pix_rd cycles per frame (384000 with defaults).
REQ-029 SHALL ignore pix_data in cycles not following a pix_rd.

Reset
REQ-030 SHALL, while rst=1 (asynchronously), force hcnt=0, vcnt=0, VGA_HS=1, VGA_VS=1, VGA_BLANK=0, VGA_R/G/B=0; pix_rd and frame_start are driven combinationally from the counters.
REQ-031 SHALL restart at pixel (0,0) after rst falls mid-frame: frame_start fires in the first cycle and no partial frame resumes.

Configuration
REQ-032 SHALL, with VGA_TEST_PATTERN_EN defined, output eight vertical colour bars of width HDISP/8 from the delayed hcnt, ignoring pix_data; pix_rd still toggles per REQ-022.
REQ-033 SHALL, without VGA_TEST_PATTERN_EN, drive VGA_R/G/B from pix_data[23:16], [15:8] and [7:0].

Verification
REQ-034 Reset: assert rst asynchronously mid-line -> outputs match REQ-030 immediately, with no clk edge required.
REQ-035 Line timing: free run -> VGA_HS period 928 clk and low width 48 clk; VGA_BLANK high 800 clk per active line.
REQ-036 Frame timing: free run -> VGA_VS period 928*525 clk, low for 3*928 clk; frame_start once per 487200 clk.
REQ-037 Data path: pix_data = {pixel_y[7:0], pixel_x[7:0], 8'hA5} delayed one cycle -> VGA_R/G/B equal that pattern on every blank-high cycle; pix_rd count per frame is 384000.
REQ-038 Mid-frame reset: release rst at vcnt=200 -> next frame_start occurs in the first cycle after release, and VS timing restarts from (0,0).
REQ-039 With VGA_TEST_PATTERN_EN defined: pix_data = 0 -> 8 bars of 100 pixels each, bar 0 white and bar 7 black.
